// File: rtl/pattern_counter_pkg.sv
// Shared constants for the serial pattern counter.
// Mode encodings and window-state encodings.
package pattern_counter_pkg;

  localparam logic MODE_OVERLAP    = 1'b0;
  localparam logic MODE_NONOVERLAP = 1'b1;

  localparam logic WIN_FILLING = 1'b0;
  localparam logic WIN_ARMED   = 1'b1;

endpackage

// File: rtl/pattern_window.sv
// Serial window shift register, fill tracker and pattern compare.
// Ports: clk, rst_n, x, valid, flush, nonovl, pat -> hit.
module pattern_window
  import pattern_counter_pkg::*;
#(
  parameter int PAT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             x,
  input  logic             valid,
  input  logic             flush,
  input  logic             nonovl,
  input  logic [PAT_W-1:0] pat,
  output logic             hit
);

  localparam int FW = $clog2(PAT_W + 1);
  localparam logic [FW-1:0] FULL = FW'(PAT_W);

  logic [PAT_W-1:0] win;
  logic [PAT_W-1:0] win_nx;
  logic [FW-1:0]    fill;
  logic [FW-1:0]    fill_nx;
  logic             wst;

  always_comb begin
    wst     = (fill == FULL) ? WIN_ARMED : WIN_FILLING;
    win_nx  = {win[PAT_W-2:0], x};
    fill_nx = (wst == WIN_ARMED) ? FULL : fill + FW'(1);
    // a flushed bit is discarded, so it can never hit
    hit     = valid & ~flush
            & (fill_nx == FULL)
            & (win_nx == pat);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win  <= '0;
      fill <= '0;
    end else if (flush) begin
      win  <= '0;
      fill <= '0;
    end else if (valid) begin
      win  <= win_nx;
      // non-overlap restarts the fill so a full fresh pattern is needed
      fill <= (hit && nonovl) ? '0 : fill_nx;
    end
  end

endmodule

// File: rtl/pattern_counter_param.sv
// Programmable serial pattern counter with saturation and overflow.
// Ports: clk, rst_n, X, x_valid, clear, cfg_* -> match, Y, overflow.
module pattern_counter_param
  import pattern_counter_pkg::*;
#(
  parameter int PAT_W = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             X,
  input  logic             x_valid,
  input  logic             clear,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pat,
  input  logic             cfg_type,
  output logic             match,
  output logic [CNT_W-1:0] Y,
  output logic             overflow
);

  localparam logic [CNT_W-1:0] YMAX = '1;

  logic [PAT_W-1:0] pat_q;
  logic             type_q;
  logic             flush;
  logic             hit;

  assign flush = clear | cfg_load;

  pattern_window #(
    .PAT_W (PAT_W)
  ) u_win (
    .clk    (clk),
    .rst_n  (rst_n),
    .x      (X),
    .valid  (x_valid),
    .flush  (flush),
    .nonovl (type_q == MODE_NONOVERLAP),
    .pat    (pat_q),
    .hit    (hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_q  <= '0;
      type_q <= MODE_OVERLAP;
    end else if (cfg_load) begin
      pat_q  <= cfg_pat;
      type_q <= cfg_type;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match    <= 1'b0;
      Y        <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      match    <= 1'b0;
      Y        <= '0;
      overflow <= 1'b0;
    end else begin
      match <= hit;
      if (hit) begin
        // saturate; a match at max is only recorded as overflow
        if (Y == YMAX) overflow <= 1'b1;
        else           Y        <= Y + CNT_W'(1);
      end
    end
  end

endmodule
